// File: rtl/inst_encoder.sv
// inst_encoder
//
// Two-stage RISC-V instruction encoder. Takes decoded fields (format, opcode,
// register indices, funct bits, full-value immediate) and packs them into a
// 32-bit instruction word. The immediate is scattered into the bit positions
// of its format. A range-error flag is raised when the immediate cannot be
// represented exactly. Running counts of emitted and faulty words are kept.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid / in_ready       input field-bundle handshake
//   in_type                   format (R/I/S/B/U/J/LI/LJ)
//   in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm
//                             decoded instruction fields
//   out_valid / out_ready     output word handshake
//   out_inst, out_err         packed word and its range-error flag
//   inst_cnt, err_cnt         completed output handshakes (all / with error)

module inst_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_type,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic [CNT_W-1:0] inst_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [2:0] RTYPE  = 3'b000;
    localparam logic [2:0] ITYPE  = 3'b001;
    localparam logic [2:0] STYPE  = 3'b010;
    localparam logic [2:0] BTYPE  = 3'b011;
    localparam logic [2:0] UTYPE  = 3'b100;
    localparam logic [2:0] JTYPE  = 3'b101;
    localparam logic [2:0] LITYPE = 3'b110;
    localparam logic [2:0] LJTYPE = 3'b111;

    logic        s1_valid_reg;
    logic [31:0] s1_inst_reg;
    logic        s1_err_reg;
    logic        s2_valid_reg;
    logic [31:0] s2_inst_reg;
    logic        s2_err_reg;
    logic [CNT_W-1:0] inst_cnt_reg;
    logic [CNT_W-1:0] err_cnt_reg;

    logic [31:0] pack_word;
    logic        pack_err;
    logic        s2_load;
    logic        accept;
    logic        out_fire;

    // Word packing and range check. The range check requires that every
    // immediate bit above the encoded sign bit is a copy of that sign bit.
    // Branch and jump offsets must also be even. On error the word is still
    // packed from the truncated bits.
    always_comb begin
        pack_word = '0;
        pack_err  = 1'b0;
        case (in_type)
            RTYPE: begin
                pack_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            end
            ITYPE, LITYPE, LJTYPE: begin
                pack_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                pack_err  = (in_imm[31:11] != {21{in_imm[11]}});
            end
            STYPE: begin
                pack_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                pack_err  = (in_imm[31:11] != {21{in_imm[11]}});
            end
            BTYPE: begin
                pack_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:1], in_imm[11], in_opcode};
                pack_err  = (in_imm[31:12] != {20{in_imm[12]}}) | in_imm[0];
            end
            UTYPE: begin
                pack_word = {in_imm[31:12], in_rd, in_opcode};
                pack_err  = |in_imm[11:0];
            end
            JTYPE: begin
                pack_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                             in_rd, in_opcode};
                pack_err  = (in_imm[31:20] != {12{in_imm[20]}}) | in_imm[0];
            end
        endcase
    end

    // S2 can take a new word when it is empty or its word leaves this cycle.
    // in_ready depends only on registered state and out_ready, so there is
    // no combinational path from in_valid.
    assign out_fire = s2_valid_reg & out_ready;
    assign s2_load  = ~s2_valid_reg | out_ready;
    assign in_ready = ~s1_valid_reg | s2_load;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_inst_reg  <= '0;
            s1_err_reg   <= 1'b0;
            s2_valid_reg <= 1'b0;
            s2_inst_reg  <= '0;
            s2_err_reg   <= 1'b0;
            inst_cnt_reg <= '0;
            err_cnt_reg  <= '0;
        end else begin
            // Accept and advance can happen on the same edge without a bubble.
            if (accept) begin
                s1_valid_reg <= 1'b1;
                s1_inst_reg  <= pack_word;
                s1_err_reg   <= pack_err;
            end else if (s2_load) begin
                s1_valid_reg <= 1'b0;
            end

            if (s2_load) begin
                s2_valid_reg <= s1_valid_reg;
                // Keep the data registers quiet when no word is moving.
                if (s1_valid_reg) begin
                    s2_inst_reg <= s1_inst_reg;
                    s2_err_reg  <= s1_err_reg;
                end
            end

            if (out_fire) begin
                inst_cnt_reg <= inst_cnt_reg + CNT_W'(1);
                if (s2_err_reg) begin
                    err_cnt_reg <= err_cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_inst  = s2_inst_reg;
    assign out_err   = s2_err_reg;
    assign inst_cnt  = inst_cnt_reg;
    assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_inst_encoder.sv
// Testbench for inst_encoder. Stimulus pushes the hand-computed word for each
// accepted bundle into a scoreboard queue. A monitor on the falling edge pops
// and compares on every output handshake. It also tracks the counters and
// checks that a stalled word is held stable.

module tb_inst_encoder;

    localparam int CNT_W = 4;

    localparam logic [2:0] RT = 3'b000;
    localparam logic [2:0] IT = 3'b001;
    localparam logic [2:0] ST = 3'b010;
    localparam logic [2:0] BT = 3'b011;
    localparam logic [2:0] UT = 3'b100;
    localparam logic [2:0] JT = 3'b101;
    localparam logic [2:0] LI = 3'b110;
    localparam logic [2:0] LJ = 3'b111;

    typedef struct {
        logic [2:0]  t;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] inst;
        logic        err;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_type = '0;
    logic [6:0]       in_opcode = '0;
    logic [4:0]       in_rd = '0;
    logic [4:0]       in_rs1 = '0;
    logic [4:0]       in_rs2 = '0;
    logic [2:0]       in_funct3 = '0;
    logic [6:0]       in_funct7 = '0;
    logic [31:0]      in_imm = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_inst;
    logic             out_err;
    logic [CNT_W-1:0] inst_cnt;
    logic [CNT_W-1:0] err_cnt;

    inst_encoder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_type   (in_type),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .inst_cnt  (inst_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int accepts  = 0;
    logic [32:0] sb_q[$];
    int hs_cycles[$];
    logic [CNT_W-1:0] exp_inst_cnt = '0;
    logic [CNT_W-1:0] exp_err_cnt  = '0;
    logic        held_valid = 1'b0;
    logic [32:0] held_word  = '0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] t, input logic [6:0] op,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] imm,
                                input logic [31:0] inst, input logic err);
        vec_t v;
        v.t = t; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.f3 = f3; v.f7 = f7; v.imm = imm; v.inst = inst; v.err = err;
        return v;
    endfunction

    // Called at #1 after a rising edge; returns at #1 after the accept edge.
    task automatic send(input vec_t v);
        int waited;
        waited    = 0;
        in_valid  = 1'b1;
        in_type   = v.t;
        in_opcode = v.op;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_funct3 = v.f3;
        in_funct7 = v.f7;
        in_imm    = v.imm;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0, required 1 within 100 cycles");
        end else begin
            sb_q.push_back({v.err, v.inst});
            accepts++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sb_q.size() != 0 || out_valid) && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (sb_q.size() != 0 || out_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d words pending, required 0", sb_q.size());
        end
    endtask

    // Monitor: on the falling edge, a visible out_valid & out_ready is the
    // handshake that completes on the next rising edge.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst) begin
            sb_q.delete();
            exp_inst_cnt = '0;
            exp_err_cnt  = '0;
            held_valid   = 1'b0;
        end else begin
            check("inst_cnt", 32'(inst_cnt), 32'(exp_inst_cnt));
            check("err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
            if (out_valid) begin
                if (held_valid) begin
                    check("hold_inst", out_inst, held_word[31:0]);
                    check("hold_err", 32'(out_err), 32'(held_word[32]));
                end
                if (out_ready) begin
                    held_valid = 1'b0;
                    hs_cycles.push_back(cyc);
                    exp_inst_cnt++;
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got 0x%08h, required no word", out_inst);
                        if (out_err) exp_err_cnt++;
                    end else begin
                        e = sb_q.pop_front();
                        $display("emit inst=0x%08h err=%0d (expected 0x%08h err=%0d)",
                                 out_inst, out_err, e[31:0], e[32]);
                        check("out_inst", out_inst, e[31:0]);
                        check("out_err", 32'(out_err), 32'(e[32]));
                        if (e[32]) exp_err_cnt++;
                    end
                end else begin
                    held_valid = 1'b1;
                    held_word  = {out_err, out_inst};
                end
            end else begin
                held_valid = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t bp[4];
        int acc_base;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_inst", out_inst, 32'h0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_inst_cnt", 32'(inst_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single ITYPE with latency check
        send(mk(IT, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0));
        check("lat_not_yet", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_out_valid", 32'(out_valid), 32'd1);
        check("lat_out_inst", out_inst, 32'h00500093);
        drain();
        check("first_inst_cnt", 32'(inst_cnt), 32'd1);

        // Back-to-back, one per cycle
        hs_cycles.delete();
        send(mk(ST, 7'b0100011, 5'd0, 5'd3, 5'd2, 3'b010, 7'd0, 32'd8, 32'h0021A423, 1'b0));
        send(mk(BT, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0));
        send(mk(UT, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0));
        send(mk(JT, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h001000EF, 1'b0));
        drain();
        check("b2b_count", 32'(hs_cycles.size()), 32'd4);
        if (hs_cycles.size() == 4)
            check("b2b_span", 32'(hs_cycles[3] - hs_cycles[0]), 32'd3);

        // Range errors
        send(mk(IT, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h80000093, 1'b1));
        send(mk(BT, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h00000163, 1'b1));
        send(mk(UT, 7'b0110111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h00000037, 1'b1));
        drain();
        check("err_cnt_3", 32'(err_cnt), 32'd3);
        check("inst_cnt_8", 32'(inst_cnt), 32'd8);

        // Other formats and boundaries
        send(mk(RT, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 1'b0));
        send(mk(RT, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEADBEEF, 32'h402081B3, 1'b0));
        send(mk(LI, 7'b0000011, 5'd2, 5'd1, 5'd0, 3'b010, 7'd0, 32'hFFFFFFFF, 32'hFFF0A103, 1'b0));
        send(mk(LJ, 7'b1100111, 5'd0, 5'd1, 5'd0, 3'd0, 7'd0, 32'd0, 32'h00008067, 1'b0));
        send(mk(JT, 7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000, 32'h8000006F, 1'b1));
        send(mk(ST, 7'b0100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 32'h80000023, 1'b0));
        drain();
        check("inst_cnt_14", 32'(inst_cnt), 32'd14);
        check("err_cnt_4", 32'(err_cnt), 32'd4);

        // Backpressure: 6 stalled cycles with 4 bundles offered
        bp[0] = mk(IT, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h00100093, 1'b0);
        bp[1] = mk(IT, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h00200113, 1'b0);
        bp[2] = mk(IT, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h00300193, 1'b0);
        bp[3] = mk(IT, 7'b0010011, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, 32'h00400213, 1'b0);
        acc_base  = accepts;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(bp[i]);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                check("bp_accepts", 32'(accepts - acc_base), 32'd2);
                check("bp_in_ready", 32'(in_ready), 32'd0);
                check("bp_head_inst", out_inst, 32'h00100093);
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_inst_cnt_wrap", 32'(inst_cnt), 32'd2);

        // Reset with two words buffered
        out_ready = 1'b0;
        send(bp[0]);
        send(bp[1]);
        check("rs_full_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("rs_out_valid", 32'(out_valid), 32'd0);
        check("rs_inst_cnt", 32'(inst_cnt), 32'd0);
        check("rs_err_cnt", 32'(err_cnt), 32'd0);
        check("rs_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(mk(UT, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0));
        drain();
        check("rs_next_inst_cnt", 32'(inst_cnt), 32'd1);

        // Counter wrap: 17 handshakes total since reset
        for (int i = 0; i < 16; i++) send(bp[0]);
        drain();
        check("wrap_inst_cnt", 32'(inst_cnt), 32'd1);
        check("wrap_err_cnt", 32'(err_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
